// File: rtl/muldiv_pkg.sv
// Shared types and opcode constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} md_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, subtract-restore for divide.
// Multiply: {acc,q} holds the running product, q[0] is the next multiplier bit.
// Divide:   acc is the partial remainder, q shifts the dividend out and quotient bits in.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Single iteration; the divide borrow is the top bit of the widened difference
    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        acc_o   = acc_i;
        q_o     = q_i;
        if (is_div) begin
            shifted = {acc_i, q_i[XLEN-1]};
            diff    = shifted - {1'b0, opnd_i};
            if (diff[XLEN]) begin
                acc_o = shifted[XLEN-1:0];
                q_o   = {q_i[XLEN-2:0], 1'b0};
            end else begin
                acc_o = diff[XLEN-1:0];
                q_o   = {q_i[XLEN-2:0], 1'b1};
            end
        end else begin
            sum   = {1'b0, acc_i} + (q_i[0] ? {1'b0, opnd_i} : '0);
            acc_o = sum[XLEN:1];
            q_o   = {sum[0], q_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer: accepts one op in IDLE, runs XLEN iterations on
// magnitudes, applies sign fixup, then presents the result for one DONE cycle.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] acc_q, acc_d, q_q, q_d, opnd_q, opnd_d;
    logic [XLEN-1:0] pend_q, pend_d, result_q, result_d;

    logic            accept, a_signed, b_signed, sa, sb, in_div, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, step_acc, step_q, fix_res;
    logic [2*XLEN-1:0] prod, prod_s;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (f3_q[2]),
        .acc_i  (acc_q),
        .q_i    (q_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc),
        .q_o    (step_q)
    );

    // Accept-time decode: operand signedness, magnitudes and short-circuit cases
    always_comb begin
        accept   = start && (state_q == IDLE) && !flush;
        a_signed = (Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) ||
                   (Funct3 == F3_DIV)  || (Funct3 == F3_REM);
        b_signed = (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
        sa       = a_signed && rs1[XLEN-1];
        sb       = b_signed && rs2[XLEN-1];
        abs_a    = sa ? -rs1 : rs1;
        abs_b    = sb ? -rs2 : rs2;
        in_div   = Funct3[2];
        div_zero = in_div && (rs2 == '0);
        div_ovf  = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                   (rs1 == MIN_NEG) && (rs2 == '1);
    end

    // Sign fixup of the magnitude result; neg_q already reflects the op's sign rule
    always_comb begin
        prod   = {acc_q, q_q};
        prod_s = neg_q ? -prod : prod;
        case (f3_q)
            F3_MUL:                       fix_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = neg_q ? -q_q : q_q;
            default:                      fix_res = neg_q ? -acc_q : acc_q;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        q_d      = q_q;
        opnd_d   = opnd_q;
        pend_d   = pend_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    f3_d  = Funct3;
                    // Remainder follows the dividend; everything else follows sign product
                    neg_d = (Funct3 == F3_REM) ? sa : (sa ^ sb);
                    if (div_zero) begin
                        pend_d  = Funct3[1] ? rs1 : '1;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        pend_d  = Funct3[1] ? '0 : MIN_NEG;
                        state_d = DONE;
                    end else begin
                        acc_d   = '0;
                        q_d     = in_div ? abs_a : abs_b;
                        opnd_d  = in_div ? abs_b : abs_a;
                        cnt_d   = CNT_W'(XLEN - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                q_d   = step_q;
                if (cnt_q == '0) state_d = FIXUP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FIXUP: begin
                pend_d  = fix_res;
                state_d = DONE;
            end
            default: begin
                result_d = pend_q;
                state_d  = IDLE;
            end
        endcase
        // A flush kills whatever is in flight without touching the delivered result
        if (flush && (state_q != IDLE)) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            q_q      <= '0;
            opnd_q   <= '0;
            pend_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            opnd_q   <= opnd_d;
            pend_q   <= pend_d;
            result_q <= result_d;
        end
    end

    // Outputs: DONE shows the fresh result unless a flush kills it this cycle
    always_comb begin
        stall  = (start && (state_q == IDLE) && !flush) ||
                 (state_q == CALC) || (state_q == FIXUP);
        done   = (state_q == DONE) && !flush;
        result = done ? pend_q : result_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  Funct3 = 3'd0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        flush = 1'b0;
    logic        stall, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_res = '0;

    localparam logic [31:0] MINV = 32'h8000_0000;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .rs1(rs1), .rs2(rs2), .flush(flush),
        .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op at cycle 0 and follow it to its done cycle (bounded)
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int poke_cyc, output logic [31:0] res, output int lat,
                          output logic stall_bad, output logic stall_at_done);
        int cyc;
        stall_bad = 1'b0;
        Funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
        #1;
        if (stall !== 1'b1) stall_bad = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; Funct3 = 3'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (stall !== 1'b1) stall_bad = 1'b1;
            if (cyc == poke_cyc) begin
                start = 1'b1; Funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        lat = (done === 1'b1) ? cyc : -1;
        res = result;
        stall_at_done = stall;
        @(posedge clk); #1;
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int poke_cyc);
        logic [31:0] res, exp;
        int lat;
        logic sbad, sdone;
        exp = ref_res(f3, a, b);
        run_op(f3, a, b, poke_cyc, res, lat, sbad, sdone);
        chk({tag, "_res"}, res, exp);
        chk({tag, "_lat"}, 32'(lat), 32'(ref_lat(f3, a, b)));
        chk({tag, "_stall_busy"}, 32'(sbad), 32'd0);
        chk({tag, "_stall_done"}, 32'(sdone), 32'd0);
        chk({tag, "_hold"}, result, exp);
        last_res = exp;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Multiply family
        do_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        do_op("mulh_min", 3'd1, MINV, MINV, 0);
        do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("mulhsu_-1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);

        // Divide family
        do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
        do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
        do_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);

        // Special cases: single-cycle
        do_op("div_by0", 3'd4, 32'd5, 32'd0, 0);
        do_op("rem_by0", 3'd6, 32'd5, 32'd0, 0);
        do_op("divu_by0", 3'd5, 32'd9, 32'd0, 0);
        do_op("div_ovf", 3'd4, MINV, 32'hFFFF_FFFF, 0);
        do_op("rem_ovf", 3'd6, MINV, 32'hFFFF_FFFF, 0);

        // Flush at cycle 10 of a DIV, then back-to-back issue
        Funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
        flush = 1'b1;
        #1;
        chk("flush_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle_stall", 32'(stall), 32'd0);
        chk("flush_no_done", 32'(done), 32'd0);
        chk("flush_result", result, last_res);
        do_op("after_flush", 3'd5, 32'd1000, 32'd3, 0);

        // Flush in the DONE cycle of a short-circuit op kills the pulse
        Funct3 = 3'd4; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1;
        #1;
        chk("flush_in_done_pulse", 32'(done), 32'd0);
        chk("flush_in_done_res", result, last_res);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_done_after", result, last_res);

        // start together with flush in IDLE is not accepted
        Funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1; flush = 1'b1;
        #1;
        chk("flush_start_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_noacc", 32'(stall), 32'd0);

        // start while busy is ignored
        do_op("busy_poke", 3'd1, 32'h1234_5678, 32'hFEDC_BA98, 6);

        // Reset mid-op
        Funct3 = 3'd0; rs1 = 32'd11; rs2 = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 5; i++) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        last_res = '0;
        @(posedge clk); #1;
        chk("rst_mid_idle", 32'(stall), 32'd0);
        do_op("after_rst", 3'd0, 32'd11, 32'd13, 0);

        // Randomized ops
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int mode;
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 5);
            if (mode == 0) b = '0;
            else if (mode == 1) begin a = MINV; b = 32'hFFFF_FFFF; end
            else if (mode == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
            else if (mode == 3 && a[0]) a = -a;
            do_op($sformatf("rnd%0d_f%0d", k, f3), f3, a, b, (k % 4 == 0) ? 3 + k % 20 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
